// File: rtl/timer_pkg.sv
// Shared constants and elaboration-time helpers for the game timer bank.
package timer_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Bits needed to hold 0..n-1, never fewer than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: o_Tick is high for one clk_50M cycle out of every DIV.
module tick_prescaler import timer_pkg::*; #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 2_000
) (
    input  logic clk_50M,
    input  logic i_Reset,
    output logic o_Tick
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW  = clog2_min1(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q;

    // NOTE: reset is sampled on the clock edge (synchronous), so it lives inside
    // the posedge branch rather than in the sensitivity list.
    always_ff @(posedge clk_50M) begin
        if (i_Reset)
            presc_q <= '0;
        else if (presc_q == LAST)
            presc_q <= '0;
        else
            presc_q <= presc_q + 1'b1;
    end

    assign o_Tick = (presc_q == LAST);

endmodule

// File: rtl/timer_bank.sv
// Bank of N_CH independent one-shot/periodic timers sharing one tick prescaler.
module timer_bank import timer_pkg::*; #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 2_000,
    parameter int N_CH    = 4,
    parameter int WIDTH   = 12
) (
    input  logic                  clk_50M,
    input  logic                  i_Reset,
    input  logic [N_CH-1:0]       i_Start,
    input  logic [N_CH-1:0]       i_Stop,
    input  logic [N_CH-1:0]       i_Clear,
    input  logic [N_CH-1:0]       i_Mode,
    input  logic [N_CH*WIDTH-1:0] i_Limit,
    output logic [N_CH*WIDTH-1:0] o_Count,
    output logic [N_CH-1:0]       o_Busy,
    output logic [N_CH-1:0]       o_Done,
    output logic [N_CH-1:0]       o_Expire,
    output logic                  o_Tick
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

    if (DIV < 2) begin : g_bad_div
        $error("timer_bank: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
        $error("timer_bank: N_CH must be within 1..8");
    end

    logic tick;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_prescaler (
        .clk_50M(clk_50M),
        .i_Reset(i_Reset),
        .o_Tick (tick)
    );

    assign o_Tick = tick;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [WIDTH-1:0] count_q, limit_q, limit_in, count_inc;
        logic             mode_q, busy_q, done_q, expire_q;

        assign limit_in  = i_Limit[k*WIDTH +: WIDTH];
        assign count_inc = count_q + 1'b1;

        // Clear > stop > start > tick; expire is gated by its own previous value
        // so a held start with limit 0 cannot pulse on consecutive cycles.
        // NOTE: all state here uses non-blocking assignments so every channel
        // reads pre-edge values regardless of statement order.
        always_ff @(posedge clk_50M) begin
            if (i_Reset) begin
                count_q  <= '0;
                limit_q  <= '0;
                mode_q   <= MODE_ONESHOT;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
                expire_q <= 1'b0;
            end else begin
                expire_q <= 1'b0;
                if (i_Clear[k]) begin
                    count_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end else if (i_Stop[k]) begin
                    busy_q <= 1'b0;
                end else if (i_Start[k]) begin
                    count_q <= '0;
                    limit_q <= limit_in;
                    mode_q  <= i_Mode[k];
                    if (limit_in == '0) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        expire_q <= ~expire_q;
                    end else begin
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end else if (tick && busy_q) begin
                    if (count_inc == limit_q) begin
                        expire_q <= ~expire_q;
                        done_q   <= 1'b1;
                        if (mode_q == MODE_PERIODIC) begin
                            count_q <= '0;
                        end else begin
                            count_q <= limit_q;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        count_q <= count_inc;
                    end
                end
            end
        end

        assign o_Count[k*WIDTH +: WIDTH] = count_q;
        assign o_Busy[k]   = busy_q;
        assign o_Done[k]   = done_q;
        assign o_Expire[k] = expire_q;
    end

endmodule

// File: tb/tb_timer_bank.sv
// Randomized and directed bench for timer_bank against an event-level reference model.
module tb_timer_bank;

    localparam int CLK_HZ  = 8;
    localparam int TICK_HZ = 2;
    localparam int DIV     = 4;
    localparam int N_CH    = 2;
    localparam int WIDTH   = 4;

    logic                  clk_50M = 1'b0;
    logic                  i_Reset;
    logic [N_CH-1:0]       i_Start, i_Stop, i_Clear, i_Mode;
    logic [N_CH*WIDTH-1:0] i_Limit;
    logic [N_CH*WIDTH-1:0] o_Count;
    logic [N_CH-1:0]       o_Busy, o_Done, o_Expire;
    logic                  o_Tick;

    timer_bank #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .N_CH   (N_CH),
        .WIDTH  (WIDTH)
    ) dut (
        .clk_50M (clk_50M),
        .i_Reset (i_Reset),
        .i_Start (i_Start),
        .i_Stop  (i_Stop),
        .i_Clear (i_Clear),
        .i_Mode  (i_Mode),
        .i_Limit (i_Limit),
        .o_Count (o_Count),
        .o_Busy  (o_Busy),
        .o_Done  (o_Done),
        .o_Expire(o_Expire),
        .o_Tick  (o_Tick)
    );

    always #5 clk_50M = ~clk_50M;

    int n_tests = 0;
    int n_fail  = 0;

    // Outputs captured at the falling edge of the current cycle.
    logic                  s_tick;
    logic [N_CH*WIDTH-1:0] s_count;
    logic [N_CH-1:0]       s_busy, s_done, s_exp;

    // Reference model: cycles since reset plus per-channel timer state.
    int m_cyc;
    int m_cnt  [N_CH];
    int m_lim  [N_CH];
    bit m_per  [N_CH];
    bit m_busy [N_CH];
    bit m_done [N_CH];
    bit m_exp  [N_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int k);
        return int'(s_count[k*WIDTH +: WIDTH]);
    endfunction

    // Apply one clock edge's worth of the timer rules to the model.
    task automatic model_step();
        bit tick;
        tick = (m_cyc % DIV) == DIV - 1;
        for (int k = 0; k < N_CH; k++) begin
            bit fire;
            int lim_in;
            fire   = 1'b0;
            lim_in = int'(i_Limit[k*WIDTH +: WIDTH]);
            if (i_Reset) begin
                m_cnt[k] = 0; m_lim[k] = 0; m_per[k] = 1'b0;
                m_busy[k] = 1'b0; m_done[k] = 1'b0;
            end else if (i_Clear[k]) begin
                m_cnt[k] = 0; m_busy[k] = 1'b0; m_done[k] = 1'b0;
            end else if (i_Stop[k]) begin
                m_busy[k] = 1'b0;
            end else if (i_Start[k]) begin
                m_cnt[k] = 0;
                m_lim[k] = lim_in;
                m_per[k] = i_Mode[k];
                m_busy[k] = (lim_in != 0);
                m_done[k] = (lim_in == 0);
                fire = (lim_in == 0);
            end else if (tick && m_busy[k]) begin
                if (m_cnt[k] + 1 == m_lim[k]) begin
                    fire = 1'b1;
                    m_done[k] = 1'b1;
                    if (m_per[k]) begin
                        m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = m_lim[k];
                        m_busy[k] = 1'b0;
                    end
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
            m_exp[k] = !i_Reset && fire && !m_exp[k];
        end
        m_cyc = i_Reset ? 0 : m_cyc + 1;
    endtask

    task automatic sample_phase();
        @(negedge clk_50M);
        s_tick  = o_Tick;
        s_count = o_Count;
        s_busy  = o_Busy;
        s_done  = o_Done;
        s_exp   = o_Expire;
        check("tick", s_tick, (m_cyc % DIV) == DIV - 1);
        for (int k = 0; k < N_CH; k++) begin
            check($sformatf("count%0d", k), cnt_of(k), m_cnt[k]);
            check($sformatf("busy%0d", k), s_busy[k], m_busy[k]);
            check($sformatf("done%0d", k), s_done[k], m_done[k]);
            check($sformatf("expire%0d", k), s_exp[k], m_exp[k]);
        end
    endtask

    task automatic edge_phase();
        model_step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic cycle();
        sample_phase();
        edge_phase();
    endtask

    task automatic start_ch(input int k, input int lim, input bit periodic);
        i_Start[k] = 1'b1;
        i_Mode[k]  = periodic;
        i_Limit[k*WIDTH +: WIDTH] = WIDTH'(lim);
    endtask

    // Both waits return right after a sample, before the next edge.
    task automatic wait_count(input int k, input int val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            sample_phase();
            if (cnt_of(k) == val) begin
                ok = 1'b1;
                return;
            end
            edge_phase();
        end
        sample_phase();
    endtask

    task automatic wait_expire(input int k, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            sample_phase();
            if (s_exp[k]) begin
                ok = 1'b1;
                return;
            end
            edge_phase();
        end
        sample_phase();
    endtask

    initial begin
        bit ok;
        int first_tick;
        int n_exp;
        int max_cnt;
        bit any_exp;

        i_Reset = 1'b1;
        i_Start = '0; i_Stop = '0; i_Clear = '0; i_Mode = '0; i_Limit = '0;
        m_cyc = 0;
        for (int k = 0; k < N_CH; k++) begin
            m_cnt[k] = 0; m_lim[k] = 0; m_per[k] = 1'b0;
            m_busy[k] = 1'b0; m_done[k] = 1'b0; m_exp[k] = 1'b0;
        end
        @(posedge clk_50M);
        #1;
        cycle();
        cycle();
        i_Reset = 1'b0;

        // Prescaler phase after reset release.
        first_tick = -1;
        for (int i = 0; i < 8; i++) begin
            sample_phase();
            if (s_tick && first_tick < 0) first_tick = i;
            if (i == 7) check("tick_period", s_tick, 1);
            edge_phase();
        end
        check("first_tick", first_tick, 3);
        check("idle_busy", s_busy, 0);

        // Channel 0 one-shot, limit 3.
        start_ch(0, 3, 1'b0);
        cycle();
        i_Start[0] = 1'b0;
        wait_expire(0, 40, ok);
        check("oneshot_expire_seen", ok, 1);
        check("oneshot_count", cnt_of(0), 3);
        check("oneshot_done", s_done[0], 1);
        check("oneshot_busy", s_busy[0], 0);
        edge_phase();
        sample_phase();
        check("oneshot_single_pulse", s_exp[0], 0);
        check("oneshot_count_held", cnt_of(0), 3);
        edge_phase();

        // Channel 1 periodic, limit 2.
        start_ch(1, 2, 1'b1);
        cycle();
        i_Start[1] = 1'b0;
        n_exp = 0;
        max_cnt = 0;
        for (int i = 0; i < 26; i++) begin
            sample_phase();
            if (s_exp[1]) n_exp++;
            if (cnt_of(1) > max_cnt) max_cnt = cnt_of(1);
            edge_phase();
        end
        check("periodic_expires", n_exp, 3);
        check("periodic_max_count", max_cnt, 1);
        check("periodic_busy", s_busy[1], 1);

        // Stop channel 0 at count 2, then restart.
        start_ch(0, 15, 1'b0);
        cycle();
        i_Start[0] = 1'b0;
        wait_count(0, 2, 40, ok);
        check("stop_reach_2", ok, 1);
        i_Stop[0] = 1'b1;
        edge_phase();
        i_Stop[0] = 1'b0;
        repeat (40) cycle();
        sample_phase();
        check("stop_frozen", cnt_of(0), 2);
        check("stop_busy", s_busy[0], 0);
        edge_phase();
        start_ch(0, 15, 1'b0);
        cycle();
        i_Start[0] = 1'b0;
        sample_phase();
        check("restart_count", cnt_of(0), 0);
        check("restart_done", s_done[0], 0);
        check("restart_busy", s_busy[0], 1);
        edge_phase();

        // Start and stop together on channel 1: stop wins.
        i_Start[1] = 1'b1;
        i_Stop[1]  = 1'b1;
        cycle();
        i_Start[1] = 1'b0;
        i_Stop[1]  = 1'b0;
        sample_phase();
        check("start_stop_busy", s_busy[1], 0);
        edge_phase();

        // Clear channel 0 while it is counting.
        repeat (6) cycle();
        i_Clear[0] = 1'b1;
        cycle();
        i_Clear[0] = 1'b0;
        any_exp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample_phase();
            if (i == 0) begin
                check("clear_count", cnt_of(0), 0);
                check("clear_done", s_done[0], 0);
                check("clear_busy", s_busy[0], 0);
            end
            if (s_exp[0]) any_exp = 1'b1;
            edge_phase();
        end
        check("clear_no_expire", any_exp, 0);

        // Degenerate limit 0 start.
        start_ch(0, 0, 1'b0);
        cycle();
        i_Start[0] = 1'b0;
        sample_phase();
        check("zero_expire", s_exp[0], 1);
        check("zero_done", s_done[0], 1);
        check("zero_busy", s_busy[0], 0);
        edge_phase();
        sample_phase();
        check("zero_single_pulse", s_exp[0], 0);
        edge_phase();

        // Reset while both channels sit at count 2.
        start_ch(0, 9, 1'b0);
        start_ch(1, 9, 1'b0);
        cycle();
        i_Start = '0;
        wait_count(0, 2, 40, ok);
        check("rst_reach_2", ok, 1);
        check("rst_ch1_at_2", cnt_of(1), 2);
        i_Reset = 1'b1;
        edge_phase();
        i_Reset = 1'b0;
        sample_phase();
        check("rst_count", s_count, 0);
        check("rst_busy", s_busy, 0);
        check("rst_done", s_done, 0);
        check("rst_expire", s_exp, 0);
        edge_phase();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            i_Reset = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < N_CH; k++) begin
                i_Start[k] = ($urandom_range(0, 19) == 0);
                i_Stop[k]  = ($urandom_range(0, 39) == 0);
                i_Clear[k] = ($urandom_range(0, 59) == 0);
                i_Mode[k]  = $urandom_range(0, 1);
                if ($urandom_range(0, 9) == 0)
                    i_Limit[k*WIDTH +: WIDTH] = WIDTH'(15);
                else
                    i_Limit[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 6));
            end
            cycle();
        end
        i_Reset = 1'b0;
        i_Start = '0; i_Stop = '0; i_Clear = '0;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
